// File: rtl/spi_register_file.sv
// spi_register_file: SPI-slave register file with per-bit set/clear/toggle, readback and soft reset.
// clk/rst: system clock, async active-high reset. COM_CLK/COM_CS/COM_MOSI/COM_MISO: SPI pins (CPOL=0, CS low).
// status: readback word at STATUS_ADDR. regs: register k at [k*DW +: DW]. frame_done/frame_err: one-clk commit pulses.
module spi_register_file #(
  parameter int NREG = 4,
  parameter int DW = 8,
  parameter int BASE_ADDR = 7,
  parameter int RESET_ADDR = 11,
  parameter int STATUS_ADDR = 12,
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic COM_CLK,
  input  logic COM_CS,
  input  logic COM_MOSI,
  output logic COM_MISO,
  input  logic [DW-1:0] status,
  output logic [NREG*DW-1:0] regs,
  output logic frame_done,
  output logic frame_err
);
  localparam int FRAME = 8 + 2*DW;
  localparam int CW = $clog2(FRAME + 2);
  logic [1:0] clk_s, cs_s, mosi_s;
  logic clk_h, cs_h;
  logic [CW-1:0] cnt;
  logic [FRAME-1:0] sr;
  logic [DW-1:0] tx, rd, set_m, clr_m;
  logic [7:0] addr_new, addr;
  logic rise, fall, cs_rise, cs_fall;
  assign rise = ~cs_s[1] & ~clk_h & clk_s[1];
  assign fall = ~cs_s[1] & clk_h & ~clk_s[1];
  assign cs_rise = cs_s[1] & ~cs_h;
  assign cs_fall = ~cs_s[1] & cs_h;
  // address byte as it completes on the 8th rise, and fields of a full frame
  assign addr_new = {sr[6:0], mosi_s[1]};
  assign addr = sr[FRAME-1 -: 8];
  assign set_m = sr[2*DW-1:DW];
  assign clr_m = sr[DW-1:0];
  always_comb begin
    rd = (addr_new == 8'(STATUS_ADDR)) ? status : '0;
    for (int k = 0; k < NREG; k++) rd = (addr_new == 8'(BASE_ADDR + k)) ? regs[k*DW +: DW] : rd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s <= '0;
      cs_s <= '1;
      mosi_s <= '0;
      clk_h <= 1'b0;
      cs_h <= 1'b1;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      regs <= {NREG{INIT}};
      COM_MISO <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], COM_CLK};
      cs_s <= {cs_s[0], COM_CS};
      mosi_s <= {mosi_s[0], COM_MOSI};
      clk_h <= clk_s[1];
      cs_h <= cs_s[1];
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall) begin
        cnt <= '0;
        tx <= '0;
      end else if (cs_rise) begin
        cnt <= '0;
        if (cnt != CW'(FRAME)) frame_err <= 1'b1;
        else begin
          frame_done <= 1'b1;
          if (addr == 8'(RESET_ADDR)) regs <= {NREG{INIT}};
          // set-only -> 1, clear-only -> 0, both -> toggle, neither -> hold
          for (int k = 0; k < NREG; k++)
            if (addr == 8'(BASE_ADDR + k))
              regs[k*DW +: DW] <= ((regs[k*DW +: DW] | set_m) & ~clr_m) | (set_m & clr_m & ~regs[k*DW +: DW]);
        end
      end else begin
        if (rise) begin
          sr <= {sr[FRAME-2:0], mosi_s[1]};
          if (cnt != CW'(FRAME + 1)) cnt <= cnt + 1'b1;
          if (cnt == CW'(7)) tx <= rd;
        end
        if (fall) begin
          COM_MISO <= (cnt >= CW'(8) && cnt < CW'(8 + DW)) ? tx[DW-1] : 1'b0;
          if (cnt >= CW'(8) && cnt < CW'(8 + DW)) tx <= tx << 1;
        end
      end
      if (cs_s[1]) COM_MISO <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_register_file.sv
// tb_spi_register_file: directed self-checking bench for spi_register_file.
module tb_spi_register_file;
  logic clk = 0, rst = 1, sclk = 0, cs = 1, mosi = 0;
  logic miso, frame_done, frame_err;
  logic [7:0] status = 8'h00;
  logic [31:0] regs;
  logic [31:0] rx;
  int checks = 0, errors = 0;
  int tot_done = 0, tot_err = 0, d0 = 0, e0 = 0;

  spi_register_file dut (
    .clk(clk), .rst(rst), .COM_CLK(sclk), .COM_CS(cs), .COM_MOSI(mosi),
    .COM_MISO(miso), .status(status), .regs(regs),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) tot_done <= tot_done + 1;
    if (frame_err) tot_err <= tot_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #40;
      rx = {rx[30:0], miso};
      sclk = 1;
      #40;
      sclk = 0;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    d0 = tot_done;
    e0 = tot_err;
    rx = '0;
    cs = 0;
    #40;
    send_bits(v, n);
    #40;
    cs = 1;
    #200;
  endtask

  initial begin
    #32;
    chk("reset_regs", regs, 32'h0);
    chk("reset_miso", {31'b0, miso}, 32'h0);
    chk("reset_done", {31'b0, frame_done}, 32'h0);
    chk("reset_err", {31'b0, frame_err}, 32'h0);
    rst = 0;
    #50;
    frame(32'h070500, 24);
    chk("write_reg0", regs, 32'h00000005);
    chk("write_done", tot_done - d0, 1);
    chk("write_err", tot_err - e0, 0);
    frame(32'h070C09, 24);
    chk("mix_reg0", regs, 32'h0000000C);
    frame(32'h08A500, 24);
    chk("write_reg1", regs, 32'h0000A50C);
    frame(32'h080000, 24);
    chk("rb_word", rx[15:8], 32'hA5);
    chk("rb_addr_bits", rx[23:16], 32'h0);
    chk("rb_tail_bits", rx[7:0], 32'h0);
    chk("rb_regs", regs, 32'h0000A50C);
    chk("rb_done", tot_done - d0, 1);
    status = 8'h3C;
    frame(32'h0C0000, 24);
    chk("status_word", rx[15:8], 32'h3C);
    chk("status_regs", regs, 32'h0000A50C);
    frame(32'h20FF00, 24);
    chk("oor_regs", regs, 32'h0000A50C);
    chk("oor_done", tot_done - d0, 1);
    frame(32'h0AFF00, 24);
    chk("write_reg3", regs, 32'hFF00A50C);
    frame(32'h0BFF00, 24);
    chk("soft_reset_regs", regs, 32'h0);
    chk("soft_reset_done", tot_done - d0, 1);
    frame(32'h070500, 24);
    frame(32'h07FF00 >> 1, 23);
    chk("short_regs", regs, 32'h00000005);
    chk("short_err", tot_err - e0, 1);
    chk("short_done", tot_done - d0, 0);
    frame({8'h0, 24'h07FF00} << 1, 25);
    chk("long_regs", regs, 32'h00000005);
    chk("long_err", tot_err - e0, 1);
    chk("long_done", tot_done - d0, 0);
    d0 = tot_done;
    e0 = tot_err;
    rx = '0;
    cs = 0;
    #40;
    send_bits(32'h07FF00 >> 12, 12);
    #20;
    rst = 1;
    #1;
    chk("arst_regs", regs, 32'h0);
    #50;
    chk("arst_done", tot_done - d0, 0);
    chk("arst_err", tot_err - e0, 0);
    rst = 0;
    #100;
    send_bits(32'hF00, 12);
    #40;
    cs = 1;
    #200;
    chk("arst_tail_err", tot_err - e0, 1);
    chk("arst_tail_done", tot_done - d0, 0);
    chk("arst_tail_regs", regs, 32'h0);
    frame(32'h07AA00, 24);
    chk("after_arst_regs", regs, 32'h000000AA);
    chk("after_arst_done", tot_done - d0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
